// File: rtl/video_timing_gen.sv
// Video timing generator. It keeps free-running pixel and line counters.
// It decodes raw hsync, vsync and de from the registered counters. Those
// three raw signals pass through a PIPE_DELAY-deep register chain. The
// block also produces a one-cycle frame_start pulse and a count of
// completed frames. All state holds while enable is low.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] counterX,
  output logic [9:0] counterY,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Three bits per pipeline stage, packed as {hs, vs, de}, newest stage lowest.
  localparam int unsigned PW = 3 * PIPE_DELAY;

  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic          fs_q, fs_d;
  logic [7:0]    fc_q, fc_d;
  logic [PW-1:0] pipe_q, pipe_d, pipe_in;
  logic [2:0]    raw;
  logic          x_end, y_end;

  // Decode raw active-high sync/de from the registered counters.
  always_comb begin
    raw[2] = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    raw[1] = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    raw[0] = (x_q < H_VIS) && (y_q < V_VIS);
  end

  // A single-stage chain cannot slice below its newest stage, so that case is split out.
  if (PIPE_DELAY == 1) begin : g_pipe_one
    assign pipe_in = raw;
  end else begin : g_pipe_many
    assign pipe_in = {pipe_q[PW-4:0], raw};
  end

  // Next-state logic: advance only on enabled cycles. frame_start clears on any held edge.
  always_comb begin
    x_end  = (x_q == H_LAST);
    y_end  = (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    fs_d   = 1'b0;
    fc_d   = fc_q;
    pipe_d = pipe_q;
    if (enable) begin
      x_d    = x_end ? '0 : x_q + 10'd1;
      pipe_d = pipe_in;
      if (x_end) begin
        y_d = y_end ? '0 : y_q + 10'd1;
      end
      if (x_end && y_end) begin
        fs_d = 1'b1;
        fc_d = fc_q + 8'd1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
      fc_q   <= '0;
      pipe_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
      fc_q   <= fc_d;
      pipe_q <= pipe_d;
    end
  end

  assign counterX    = x_q;
  assign counterY    = y_q;
  assign hsync       = pipe_q[PW-1] ^ ~HS_POL;
  assign vsync       = pipe_q[PW-2] ^ ~VS_POL;
  assign de          = pipe_q[PW-3];
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen. Three instances share one clock, one
// enable and one reset:
//   A: reduced 16x11 timing, PIPE_DELAY=1, active-low syncs
//   B: the same timing, PIPE_DELAY=3, active-high syncs
//   C: the default 800x525 timing
// The expected outputs come from the number of enabled edges since reset,
// using plain modular arithmetic.
module tb_video_timing_gen;

  logic       pixel_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic       enable    = 1'b0;

  logic [9:0] ax, ay, bx, by, cx, cy;
  logic       ahs, avs, ade, afs;
  logic       bhs, bvs, bde, bfs;
  logic       chs, cvs, cde, cfs;
  logic [7:0] afc, bfc, cfc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n        = 0;   // enabled edges since reset
  bit          last_en  = 1'b0; // most recent edge advanced the timing

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_DELAY(1)
  ) u_a (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable),
    .counterX(ax), .counterY(ay), .hsync(ahs), .vsync(avs), .de(ade),
    .frame_start(afs), .frame_count(afc)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(3)
  ) u_b (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable),
    .counterX(bx), .counterY(by), .hsync(bhs), .vsync(bvs), .de(bde),
    .frame_start(bfs), .frame_count(bfc)
  );

  video_timing_gen u_c (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .enable(enable),
    .counterX(cx), .counterY(cy), .hsync(chs), .vsync(cvs), .de(cde),
    .frame_start(cfs), .frame_count(cfc)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s t=%0t n=%0d got=%h exp=%h", tag, $time, n, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Expected {x, y, hsync, vsync, de, frame_start, frame_count} after k enabled edges.
  function automatic logic [31:0] model(input int unsigned k, input bit le,
                                        input int unsigned ha, input int unsigned hfp,
                                        input int unsigned hsw, input int unsigned hbp,
                                        input int unsigned va, input int unsigned vfp,
                                        input int unsigned vsw, input int unsigned vbp,
                                        input int unsigned pd, input bit hp, input bit vp);
    int unsigned ht, vt, ft, m, mx, my;
    bit hsa, vsa, dea, fs;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    ft  = ht * vt;
    hsa = 1'b0;
    vsa = 1'b0;
    dea = 1'b0;
    if (k >= pd) begin
      m   = k - pd;
      mx  = m % ht;
      my  = (m / ht) % vt;
      hsa = (mx >= ha + hfp) && (mx < ha + hfp + hsw);
      vsa = (my >= va + vfp) && (my < va + vfp + vsw);
      dea = (mx < ha) && (my < va);
    end
    fs = le && (k > 0) && (k % ft == 0);
    return {10'(k % ht), 10'((k / ht) % vt),
            (hp ? hsa : !hsa), (vp ? vsa : !vsa), dea, fs, 8'((k / ft) % 256)};
  endfunction

  task automatic check_all();
    check_eq("instA", {ax, ay, ahs, avs, ade, afs, afc},
             model(n, last_en, 8, 2, 3, 3, 6, 1, 2, 2, 1, 1'b0, 1'b0));
    check_eq("instB", {bx, by, bhs, bvs, bde, bfs, bfc},
             model(n, last_en, 8, 2, 3, 3, 6, 1, 2, 2, 3, 1'b1, 1'b1));
    check_eq("instC", {cx, cy, chs, cvs, cde, cfs, cfc},
             model(n, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0));
  endtask

  // Drive enable on the falling edge, update the model on the rising edge, sample 1 ns later.
  task automatic step(input logic en);
    @(negedge pixel_clk);
    enable = en;
    @(posedge pixel_clk);
    if (!reset_n) begin
      n       = 0;
      last_en = 1'b0;
    end else begin
      if (en) n++;
      last_en = en;
    end
    #1;
    check_all();
  endtask

  localparam int unsigned FT_A = 176;

  initial begin
    int unsigned guard;
    bit held_last, held_pulse;
    held_last  = 1'b0;
    held_pulse = 1'b0;

    // Reset held with enable high: everything stays at reset values.
    repeat (3) step(1'b1);
    reset_n = 1'b1;
    check_all();
    step(1'b1);
    check_eq("de_first_rise", {31'd0, ade}, 32'd1);

    // Random enable gaps across more than 256 frames of A/B, with two directed holds.
    guard = 0;
    while (n < 258 * FT_A && guard < 80000) begin
      guard++;
      if (!held_last && n == FT_A + FT_A - 1) begin
        repeat (10) step(1'b0);
        held_last = 1'b1;
      end else if (!held_pulse && held_last && n == 2 * FT_A && last_en) begin
        repeat (5) step(1'b0);
        held_pulse = 1'b1;
      end else begin
        step($urandom_range(0, 15) != 0);
      end
    end
    check_eq("long_run_budget", n >= 258 * FT_A ? 32'd1 : 32'd0, 32'd1);
    check_eq("frames_wrapped", {24'd0, afc}, 32'(((258 * FT_A) / FT_A) % 256));

    // Asynchronous reset mid-line on the default-timing instance.
    guard = 0;
    while (n % 800 != 700 && guard < 2000) begin
      guard++;
      step(1'b1);
    end
    check_eq("reach_x700", {22'd0, cx}, 32'd700);
    #2;
    reset_n = 1'b0;
    n       = 0;
    last_en = 1'b0;
    #1;
    check_all();
    repeat (2) step(1'b1);
    reset_n = 1'b1;
    check_all();
    step(1'b1);
    check_eq("de_rise_after_rst", {31'd0, cde}, 32'd1);
    repeat (1700) step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
